// File: rtl/s2_cfg_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : s2_cfg_sequencer_pkg                                            |
// | Brief  : Shared definitions for the S2 cell configuration sequencer:     |
// |          truth-table width, FSM state encoding and the odd-parity rule.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package s2_cfg_sequencer_pkg;

  // Width of one S2 cell truth table (d[3:0]).
  localparam int S2_TT_W = 4;

  // Sequencer states. Encodings are fixed so that debug probes of the
  // state register read the same across builds.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RUN    = 2'd3
  } cfg_state_t;

  // A beat is good when the parity bit plus the data has an odd number of ones.
  function automatic logic odd_parity_ok(input logic par,
                                         input logic [S2_TT_W-1:0] data);
    return ^{par, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/s2_cfg_shadow.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : s2_cfg_shadow                                                   |
// | Brief  : NUM_CELLS x S2_TT_W shadow register file. One indexed write     |
// |          port for incoming beats and a full-width parallel read used by  |
// |          the atomic commit.                                              |
// | Ports  : clk, clr (sync reset), flush (discard all entries),            |
// |          we/widx/wdata (write port), rdata (all entries, cell i at       |
// |          [S2_TT_W*i +: S2_TT_W]).                                        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module s2_cfg_shadow
  import s2_cfg_sequencer_pkg::*;
#(
  parameter int NUM_CELLS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           flush,
  input  logic                           we,
  input  logic [IDX_W-1:0]               widx,
  input  logic [S2_TT_W-1:0]             wdata,
  output logic [S2_TT_W*NUM_CELLS-1:0]   rdata
);

  generate
    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
      logic [S2_TT_W-1:0] r_tt;

      always_ff @(posedge clk) begin
        if (clr || flush) begin
          r_tt <= '0;
        end else if (we && (widx == IDX_W'(gi))) begin
          r_tt <= wdata;
        end
      end

      assign rdata[gi*S2_TT_W +: S2_TT_W] = r_tt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/s2_cfg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : s2_cfg_sequencer                                                |
// | Brief  : Configuration sequencer for a bank of S2 mux/flip-flop cells.   |
// |          Collects one truth table per cell over a valid/ready stream,    |
// |          stages them in a shadow file and commits all of them to the     |
// |          live cell_d bus in a single edge. cell_run gates the fabric so  |
// |          cells never evaluate against a half-loaded table set.           |
// | Config : S2_CFG_PARITY_EN - adds cfg_par and an odd-parity check on each |
// |          accepted beat; a bad beat aborts the load and sets sticky err.  |
// |          Undefined (default): no cfg_par port, err tied low.             |
// | Ports  : clk, clr (sync active-high reset), cfg_start, cfg_valid,        |
// |          cfg_data[3:0], cfg_par (parity build only), cfg_ready,          |
// |          cell_d[4*NUM_CELLS-1:0], cell_run, busy, done, err.             |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module s2_cfg_sequencer
  import s2_cfg_sequencer_pkg::*;
#(
  parameter int NUM_CELLS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           cfg_start,
  input  logic                           cfg_valid,
  input  logic [S2_TT_W-1:0]             cfg_data,
`ifdef S2_CFG_PARITY_EN
  input  logic                           cfg_par,
`endif
  output logic                           cfg_ready,
  output logic [S2_TT_W*NUM_CELLS-1:0]   cell_d,
  output logic                           cell_run,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

  cfg_state_t                         r_state;
  logic [IDX_W-1:0]                   r_idx;
  logic [S2_TT_W*NUM_CELLS-1:0]       w_shadow;
  logic                               w_beat;
  logic                               w_par_ok;
  logic                               w_wr;
  logic                               w_flush;

  // cfg_ready is itself registered and only high in LOAD, so this is the
  // handshake as seen by the upstream source.
  assign w_beat = (r_state == ST_LOAD) && cfg_ready && cfg_valid;

`ifdef S2_CFG_PARITY_EN
  logic r_err;
  assign w_par_ok = odd_parity_ok(cfg_par, cfg_data);
  assign err      = r_err;
`else
  assign w_par_ok = 1'b1;
  assign err      = 1'b0;
`endif

  // A bad beat is never written; instead the whole partial load is dropped.
  assign w_wr    = w_beat && w_par_ok;
  assign w_flush = w_beat && !w_par_ok;

  s2_cfg_shadow #(
    .NUM_CELLS (NUM_CELLS),
    .IDX_W     (IDX_W)
  ) u_shadow (
    .clk   (clk),
    .clr   (clr),
    .flush (w_flush),
    .we    (w_wr),
    .widx  (r_idx),
    .wdata (cfg_data),
    .rdata (w_shadow)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      cell_d    <= '0;
      cfg_ready <= 1'b0;
      cell_run  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef S2_CFG_PARITY_EN
      r_err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        // IDLE and RUN honour a start identically; leaving RUN drops
        // cell_run on the same edge while cell_d keeps the old tables.
        ST_IDLE, ST_RUN: begin
          if (cfg_start) begin
            r_state   <= ST_LOAD;
            r_idx     <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            cell_run  <= 1'b0;
`ifdef S2_CFG_PARITY_EN
            r_err     <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
`ifdef S2_CFG_PARITY_EN
          if (w_flush) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            r_err     <= 1'b1;
          end else
`endif
          if (w_wr) begin
            // The last beat closes the window on the same edge so no
            // extra beat can slip in; idx is held rather than wrapped.
            if (r_idx == LAST_IDX) begin
              r_state   <= ST_COMMIT;
              cfg_ready <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        ST_COMMIT: begin
          cell_d   <= w_shadow;
          r_state  <= ST_RUN;
          cell_run <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b1;
        end

        default: begin
          r_state   <= ST_IDLE;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
          cell_run  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_s2_cfg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_s2_cfg_sequencer                                             |
// | Brief  : Self-checking bench for s2_cfg_sequencer. A queue-based model   |
// |          predicts every output each cycle; directed scenarios add        |
// |          hand-computed literal expectations. Parity scenario runs when   |
// |          S2_CFG_PARITY_EN is defined.                                    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_s2_cfg_sequencer;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           clr;
  logic           cfg_start;
  logic           cfg_valid;
  logic [3:0]     cfg_data;
  logic           cfg_ready;
  logic [4*N-1:0] cell_d;
  logic           cell_run;
  logic           busy;
  logic           done;
  logic           err;
`ifdef S2_CFG_PARITY_EN
  logic           cfg_par;
  logic           par_flip;
  assign cfg_par = ~(^cfg_data) ^ par_flip;
`endif

  always #5 clk = ~clk;

  s2_cfg_sequencer #(.NUM_CELLS(N), .IDX_W(3)) dut (
    .clk       (clk),
    .clr       (clr),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
`ifdef S2_CFG_PARITY_EN
    .cfg_par   (cfg_par),
`endif
    .cfg_ready (cfg_ready),
    .cell_d    (cell_d),
    .cell_run  (cell_run),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  bit         m_loading, m_commit_pend, m_running, m_done, m_err;
  logic [3:0] m_beats[$];
  logic [3:0] m_live[N];

  function automatic logic [4*N-1:0] m_cell_d();
    logic [4*N-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = m_live[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_loading = 0; m_commit_pend = 0; m_running = 0; m_done = 0; m_err = 0;
      m_beats.delete();
      for (int i = 0; i < N; i++) m_live[i] = '0;
    end else begin
      m_done = 0;
      if (m_commit_pend) begin
        for (int i = 0; i < N; i++) m_live[i] = m_beats[i];
        m_beats.delete();
        m_commit_pend = 0; m_running = 1; m_done = 1;
      end else if (m_loading) begin
        if (cfg_valid) begin
`ifdef S2_CFG_PARITY_EN
          if ((^{cfg_par, cfg_data}) == 1'b0) begin
            m_loading = 0; m_err = 1; m_beats.delete();
          end else
`endif
          begin
            m_beats.push_back(cfg_data);
            if (m_beats.size() == N) begin m_loading = 0; m_commit_pend = 1; end
          end
        end
      end else if (cfg_start) begin
        m_loading = 1; m_running = 0; m_err = 0; m_beats.delete();
      end
    end
  end

  // Compare process: outputs settle after the rising edge; sample on the falling one.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cfg_ready", {63'd0, cfg_ready}, {63'd0, m_loading});
      chk("busy",      {63'd0, busy},      {63'd0, (m_loading | m_commit_pend)});
      chk("cell_run",  {63'd0, cell_run},  {63'd0, m_running});
      chk("done",      {63'd0, done},      {63'd0, m_done});
      chk("err",       {63'd0, err},       {63'd0, m_err});
      chk("cell_d",    64'(cell_d),        64'(m_cell_d()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cfg_start = 0; cfg_valid = 0; cfg_data = '0; clr = 0;
`ifdef S2_CFG_PARITY_EN
    par_flip = 0;
`endif
  endtask

  // Start + N back-to-back beats; returns with the commit visible.
  task automatic full_load(input logic [4*N-1:0] tables);
    tick(); cfg_start = 1;
    for (int i = 0; i < N; i++) begin
      tick(); cfg_start = 0; cfg_valid = 1; cfg_data = tables[4*i +: 4];
    end
    tick(); cfg_valid = 0;
    tick();
  endtask

  logic [3:0]     sent[$];
  logic [4*N-1:0] exp_v;

  initial begin
    idle_inputs();
    clr = 1;
    // 1. reset held two cycles
    tick(); tick();
    chk("rst_cell_d",   64'(cell_d), 64'd0);
    chk("rst_ready",    {63'd0, cfg_ready}, 64'd0);
    chk("rst_cell_run", {63'd0, cell_run}, 64'd0);
    chk("rst_done",     {63'd0, done}, 64'd0);
    chk("rst_err",      {63'd0, err}, 64'd0);
    clr = 0;
    chk_en = 1;

    // 3. stalled load: valid toggles, start pulsed mid-load, then a 9th beat offered
    tick(); cfg_start = 1;
    for (int c = 0; c <= 18; c++) begin
      tick();
      cfg_start = (c == 5 || c == 6);
      cfg_valid = (c >= 15) ? 1'b1 : ((c % 2) == 0);
      cfg_data  = 4'($urandom);
      if (cfg_valid && c <= 14) sent.push_back(cfg_data);
    end
    tick(); cfg_valid = 0; cfg_start = 0;
    for (int i = 0; i < N; i++) exp_v[4*i +: 4] = sent[i];
    chk("stall_cell_d", 64'(cell_d), 64'(exp_v));
    chk("stall_ready",  {63'd0, cfg_ready}, 64'd0);
    chk("stall_run",    {63'd0, cell_run}, 64'd1);

    // 2. full load 0..7, started from RUN, with exact commit latency
    tick(); cfg_start = 1;
    for (int i = 0; i < N; i++) begin
      tick(); cfg_start = 0; cfg_valid = 1; cfg_data = 4'(i);
    end
    tick(); cfg_valid = 0;
    chk("t2_pre_commit_done", {63'd0, done}, 64'd0);
    chk("t2_pre_commit_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("t2_cell_d", 64'(cell_d), 64'h76543210);
    chk("t2_done",   {63'd0, done}, 64'd1);
    chk("t2_run",    {63'd0, cell_run}, 64'd1);
    chk("t2_model_pin", 64'(m_cell_d()), 64'h76543210);
    tick();
    chk("t2_done_low", {63'd0, done}, 64'd0);

    // 4. reload 4'hF from RUN; first cycle has start and valid together
    cfg_start = 1; cfg_valid = 1; cfg_data = 4'hF;
    for (int i = 0; i < N; i++) begin
      tick(); cfg_start = 0; cfg_valid = 1; cfg_data = 4'hF;
      if (i == 0) chk("t4_ready_in_load", {63'd0, cfg_ready}, 64'd1);
      if (i == 3) begin
        chk("t4_run_low",  {63'd0, cell_run}, 64'd0);
        chk("t4_old_tbls", 64'(cell_d), 64'h76543210);
      end
    end
    tick(); cfg_valid = 0;
    chk("t4_hold_commit", 64'(cell_d), 64'h76543210);
    tick();
    chk("t4_cell_d", 64'(cell_d), 64'hFFFFFFFF);
    chk("t4_done",   {63'd0, done}, 64'd1);

    // 5. reset after three beats, then a clean load from index 0
    tick(); cfg_start = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); cfg_start = 0; cfg_valid = 1; cfg_data = 4'hA;
    end
    tick(); cfg_valid = 0; clr = 1;
    tick(); clr = 0;
    chk("t5_cell_d", 64'(cell_d), 64'd0);
    chk("t5_run",    {63'd0, cell_run}, 64'd0);
    chk("t5_ready",  {63'd0, cfg_ready}, 64'd0);
    full_load(32'h9ABCDEF8);
    chk("t5_reload", 64'(cell_d), 64'h9ABCDEF8);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      tick();
      clr       = ($urandom_range(0, 96) == 0);
      cfg_start = ($urandom_range(0, 11) == 0);
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_data  = 4'($urandom);
`ifdef S2_CFG_PARITY_EN
      par_flip  = ($urandom_range(0, 19) == 0);
`endif
    end
    tick(); idle_inputs(); clr = 1;
    tick(); clr = 0;

`ifdef S2_CFG_PARITY_EN
    // 6. parity error on beat 5 aborts the load and leaves cell_d alone
    full_load(32'h13572468);
    tick(); cfg_start = 1;
    for (int i = 0; i < 6; i++) begin
      tick(); cfg_start = 0; cfg_valid = 1; cfg_data = 4'(i + 3); par_flip = (i == 5);
    end
    tick(); cfg_valid = 0; par_flip = 0;
    chk("t6_err",    {63'd0, err}, 64'd1);
    chk("t6_ready",  {63'd0, cfg_ready}, 64'd0);
    chk("t6_run",    {63'd0, cell_run}, 64'd0);
    chk("t6_cell_d", 64'(cell_d), 64'h13572468);
    cfg_start = 1;
    tick(); cfg_start = 0;
    chk("t6_err_clr", {63'd0, err}, 64'd0);
    tick(); tick();
`endif

    tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
